port_uart_tx: RTL
=================

// Module: port_uart_tx
// PURPOSE
// - UART transmitter (8N1, LSB first) that answers the CPU I/O port bus as a memory-mapped responder.
// - CPU drives portAddress/portWrite/portRead and its dataOut; this block supplies read data and raises intReq.
// - Read data is zero-wait: combinational, so the CPU captures it in the same cycle.
// - Holds a small TX FIFO and a programmable bit timer.
// - Optional interrupt when the transmitter drains; handshakes with the CPU intAck.
// PARAMETERS
// BASE_ADDR   8'hE0  port base; 4 registers at BASE..BASE+3 (inside CPU direct range 111xxxxx)
// FIFO_DEPTH  4      TX FIFO entries; power of 2, >=2
// BAUD_RESET  8'd15  reset value of BAUD register (clocks per bit = BAUD+1)
// PORTS
// clk          in   1  system clock, rising edge
// reset        in   1  asynchronous, active-low reset
// portAddress  in   8  port address from CPU
// portRead     in   1  CPU read strobe (single cycle)
// portWrite    in   1  CPU write strobe (single cycle)
// wrData       in   8  write data (CPU dataOut)
// rdData       out  8  read data to CPU dataIn; 8'h00 when not reading this block
// intReq       out  1  interrupt request to CPU
// intAck       in   1  CPU interrupt acknowledge; high from IRQ entry until RETI
// txd          out  1  serial output, idle high
// BEHAVIOUR
// - Register map, hit = address in BASE_ADDR..BASE_ADDR+3; any other address is ignored and reads 0.
//   +0 DATA:   write pushes to FIFO; read returns 0.
//   +1 STATUS: read {3'b0, overrun, irqPend, busy, full, empty}.
//              Write: bit0=1 clears irqPend; bit1=1 clears overrun.
//   +2 CTRL:   bit0 irqEn; bits 7:1 read 0.
//   +3 BAUD:   R/W; clocks per bit = BAUD+1.
// - rdData is combinational from portAddress & portRead. Register writes take effect at the clk edge ending the strobe cycle.
// - Reset values: txd=1, intReq=0, FIFO empty, state IDLE, CTRL=0, BAUD=BAUD_RESET, irqPend=0, overrun=0.
//   A reset asserted mid-frame forces txd=1 immediately and flushes the FIFO.
// - FIFO push/pop rules:
//   - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise the byte is dropped and overrun is set (sticky).
//   - Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
// - TX FSM states, each bit lasting BAUD+1 clocks (down-counter reloaded from BAUD at every bit boundary):
//   IDLE:  txd=1. If FIFO not empty: pop into the shifter, go to START.
//   START: txd=0 for 1 bit, then DATA.
//   DATA:  txd=shift[0] for 8 bits, LSB first, then STOP.
//   STOP:  txd=1 for 1 bit, then IDLE. A byte waiting in IDLE is popped on the next cycle, giving 1 idle clock between frames.
// - Latency: DATA write in cycle N, count=1 in N+1, pop at end of N+1, txd low from N+2.
// - busy=1 in any state other than IDLE. txd is driven from a register (glitch-free).
// - A BAUD write mid-frame applies at the next bit boundary.
// - irqPend is set on the STOP->IDLE transition when the FIFO is empty.
//   It is set regardless of irqEn, so software can poll it.
// - intReq = irqPend & irqEn.
// - irqPend is cleared:
//   - on the intAck rising edge (intAck registered; clear in the cycle after the edge), or
//   - by a STATUS write with bit0=1.
//   If a set and a clear coincide, the set wins.
// - A read has no side effects.
// TESTING
// 1 Reset: release reset -> txd=1, intReq=0; read BASE+1 = 8'h01; read BASE+3 = 8'h0F.
// 2 BAUD=3, write 8'hA5 to 8'hE0 in cycle N -> txd low from N+2.
//   txd sequence 0,1,0,1,0,0,1,0,1,1 with 4 clocks each (40 clocks); STATUS busy=1 throughout.
// 3 BAUD=8'hFF, six back-to-back DATA writes -> first popped, next 4 fill FIFO, 6th dropped.
//   STATUS = 8'h16; writing STATUS 8'h02 then reading gives 8'h06.
// 4 CTRL=1, send 1 byte -> intReq=1 the cycle after STOP ends, STATUS=8'h09.
//   Raise intAck -> intReq=0 one cycle later; hold intAck, send again -> intReq re-asserts.
// 5 Decode: reads of 8'hDF and 8'hE4 return 0; write to 8'hE4 changes nothing.
//   CTRL write 8'hFF reads back 8'h01.
// 6 Assert reset during DATA bit 3 -> txd=1 asynchronously; after release STATUS=8'h01 and no residual frame is sent.

Source files
------------

// File: rtl/port_uart_tx.sv
// 8N1 LSB-first UART transmitter behind a 4-register CPU I/O port window.
// Holds a small TX FIFO and a programmable bit timer, with an optional drain interrupt.
module port_uart_tx #(
  parameter logic [7:0] BASE_ADDR  = 8'hE0,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BAUD_RESET = 8'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] portAddress,
  input  logic       portRead,
  input  logic       portWrite,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic       intReq,
  input  logic       intAck,
  output logic       txd,
  output logic [1:0] o_dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         r_state, w_next;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [7:0]     r_shift, r_baud, r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic           r_txd, r_irq_en, r_irq_pend, r_overrun, r_ack_q;

  logic [7:0]     w_offset;
  logic           w_hit, w_wr_data, w_wr_status, w_wr_ctrl, w_wr_baud;
  logic           w_pop, w_push_ok, w_bit_end, w_full, w_empty, w_busy;
  logic           w_irq_set, w_irq_clr, w_txd_next;

  // Bus: portRead/portWrite are single-cycle strobes qualified by portAddress;
  // reads are answered combinationally in the strobe cycle, writes commit at its closing edge.
  assign w_offset    = portAddress - BASE_ADDR;
  assign w_hit       = (w_offset < 8'd4);
  assign w_wr_data   = portWrite && w_hit && (w_offset[1:0] == 2'd0);
  assign w_wr_status = portWrite && w_hit && (w_offset[1:0] == 2'd1);
  assign w_wr_ctrl   = portWrite && w_hit && (w_offset[1:0] == 2'd2);
  assign w_wr_baud   = portWrite && w_hit && (w_offset[1:0] == 2'd3);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_push_ok = w_wr_data && (!w_full || w_pop);
  assign w_bit_end = (r_baud_cnt == 8'd0);
  assign w_irq_set = (r_state == S_STOP) && w_bit_end && w_empty;
  assign w_irq_clr = (intAck && !r_ack_q) || (w_wr_status && wrData[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_bit_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // txd is registered, so the line level for the coming cycle is chosen here.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wrData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txd      <= 1'b1;
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_txd <= w_txd_next;
      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_baud_cnt <= r_baud;
        r_bit_idx  <= '0;
      end else if (w_busy) begin
        if (w_bit_end) begin
          r_baud_cnt <= r_baud;
          if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt - 8'd1;
        end
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_en   <= 1'b0;
      r_baud     <= BAUD_RESET;
      r_overrun  <= 1'b0;
      r_irq_pend <= 1'b0;
      r_ack_q    <= 1'b0;
    end else begin
      r_ack_q <= intAck;
      if (w_wr_ctrl) r_irq_en <= wrData[0];
      if (w_wr_baud) r_baud   <= wrData;
      if (w_wr_data && !w_push_ok)      r_overrun <= 1'b1;
      else if (w_wr_status && wrData[1]) r_overrun <= 1'b0;
      if (w_irq_set)      r_irq_pend <= 1'b1;
      else if (w_irq_clr) r_irq_pend <= 1'b0;
    end
  end

  always_comb begin
    rdData = 8'h00;
    if (portRead && w_hit) begin
      case (w_offset[1:0])
        2'd1:    rdData = {3'b000, r_overrun, r_irq_pend, w_busy, w_full, w_empty};
        2'd2:    rdData = {7'b0, r_irq_en};
        2'd3:    rdData = r_baud;
        default: rdData = 8'h00;
      endcase
    end
  end

  assign intReq      = r_irq_pend && r_irq_en;
  assign txd         = r_txd;
  assign o_dbg_state = r_state;

endmodule
